axil_reg_arbiter: RTL and testbench
===================================

AXIL_REG_ARBITER -- requirements
Module: axil_reg_arbiter

Interface
REQ-001 Parameter C_ADDR_WIDTH, default 4, byte-address width of requests and of the AXI4-Lite master port.
REQ-002 Parameter C_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 ACLK  in  1  sole clock; all state changes on rising edge.
REQ-004 ARESETN  in  1  reset, asynchronous assertion, active-low.
REQ-005 req_valid  in  2  per-requester request pending (bit n = requester n).
REQ-006 req_write  in  2  per-requester op: 1 write, 0 read.
REQ-007 req_addr  in  2*C_ADDR_WIDTH  per-requester address; requester n in slice n.
REQ-008 req_wdata  in  2*C_DATA_WIDTH  per-requester write data; requester n in slice n.
REQ-009 req_ready  out  2  one-hot accept strobe; request n is taken on the edge where req_valid[n] and req_ready[n] are both 1.
REQ-010 rsp_valid  out  2  one-hot, one-cycle completion strobe to the granted requester.
REQ-011 rsp_rdata  out  C_DATA_WIDTH  read data of the last completion (0 for writes).
REQ-012 rsp_resp  out  2  AXI response code of the last completion.
REQ-013 M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in: AXI4-Lite write-address channel; AWPROT = 3'b000.
REQ-014 M_AXI_WDATA/WSTRB/WVALID out, WREADY in: write-data channel; WSTRB = all ones.
REQ-015 M_AXI_BRESP/BVALID in, BREADY out: write-response channel.
REQ-016 M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in: read-address channel; ARPROT = 3'b000.
REQ-017 M_AXI_RDATA/RRESP/RVALID in, RREADY out: read-data channel.

Function
REQ-018 The FSM SHALL have states IDLE, ADDR and RESP, with at most one transaction outstanding.
REQ-019 In IDLE, req_ready SHALL be driven combinationally: one-hot to the granted requester if any req_valid bit is set, otherwise 0; in ADDR and RESP it SHALL be 0.
REQ-020 Grant SHALL be round-robin on a 1-bit last_grant pointer: if both requesters are valid, the one not equal to last_grant wins; if only one is valid, it wins.
REQ-021 On accept, the block SHALL latch the grant index, op, address and data, and SHALL move to ADDR; requester inputs after accept are ignored.
REQ-022 ADDR write: AWVALID and WVALID SHALL rise in the first ADDR cycle and each SHALL fall independently after its own handshake; when both have completed, in any order or together, the FSM SHALL move to RESP.
REQ-023 ADDR read: ARVALID SHALL be held until ARREADY, then the FSM SHALL move to RESP.
REQ-024 Valid/address/data outputs SHALL stay stable while valid is high and not handshaken.
REQ-025 RESP: BREADY (write) or RREADY (read) SHALL be 1 and all other READY outputs 0; on BVALID/RVALID the block SHALL capture RDATA (read) or 0 (write) plus the response code.
REQ-026 On that capture, the registered rsp_valid[grant] SHALL pulse one cycle later, last_grant SHALL become the grant index, and the FSM SHALL return to IDLE.
REQ-027 rsp_rdata and rsp_resp SHALL hold until the next completion.
REQ-028 Minimum latency SHALL be 3 cycles from accept edge to rsp_valid, with all READY inputs and responses immediate.
REQ-029 A new accept MAY occur in the same cycle rsp_valid is high, giving back-to-back throughput of one transaction per 3 cycles.
REQ-030 SLVERR/DECERR SHALL be passed through unchanged, with no retry.
REQ-031 The block SHALL have no timeout; a slave that never responds stalls the block indefinitely.

Reset
REQ-032 While ARESETN=0, the block SHALL force state=IDLE, last_grant=1, all VALID/READY outputs=0, rsp_valid=0, and rsp_rdata/rsp_resp/latched address/data=0.
REQ-033 Reset mid-transaction SHALL abandon the in-flight transfer with no rsp_valid; after release, requester 0 SHALL win the first contention.

Verification
REQ-034 Single write: req0 write addr 0x0 data 0x00000001, slave ready -> AWVALID/WVALID next cycle, AWADDR=0x0, WDATA=0x00000001, WSTRB=0xF, rsp_valid=2'b01 with rsp_resp=OKAY 3 cycles after accept.
REQ-035 Write/readback: write 0x1..0x4 to 0x0,0x4,0x8,0xC via req0, read the same addresses via req1 -> rsp_rdata = 0x1,0x2,0x3,0x4 in order on rsp_valid=2'b10.
REQ-036 Contention: both requesters held valid from reset for 4 transactions -> grants alternate 0,1,0,1.
REQ-037 Skewed handshake: WREADY asserted 3 cycles before AWREADY, then the reverse order -> WVALID drops after its handshake, RESP is entered only after both, exactly one rsp_valid.
REQ-038 Stall/reset: slave delays RVALID 10 cycles and ARESETN pulses low at cycle 5 -> all outputs 0 immediately, no rsp_valid, next accept goes to requester 0.

Source files
------------

// File: rtl/axil_reg_arbiter.sv
// Two-requester round-robin front end onto a single AXI4-Lite master port.
// One transaction in flight at a time: IDLE accepts, ADDR issues, RESP collects.
module axil_reg_arbiter #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [1:0]                  req_valid,
  input  logic [1:0]                  req_write,
  input  logic [2*C_ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*C_DATA_WIDTH-1:0]   req_wdata,
  output logic [1:0]                  req_ready,
  output logic [1:0]                  rsp_valid,
  output logic [C_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic [C_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;

  state_t                    state_q, state_d;
  logic                      last_grant_q, last_grant_d;
  logic                      gnt_q, gnt_d;
  logic                      wr_q, wr_d;
  logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      arvalid_q, arvalid_d;
  logic [1:0]                rsp_valid_q, rsp_valid_d;
  logic [C_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic                      gnt_sel;
  logic                      bready, rready;

  // With both requesting, the one that did not complete last wins.
  always_comb begin
    if (&req_valid) gnt_sel = ~last_grant_q;
    else            gnt_sel = req_valid[1];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_resp_d   = rsp_resp_q;
    req_ready    = '0;
    bready       = 1'b0;
    rready       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready = gnt_sel ? 2'b10 : 2'b01;
          state_d   = S_ADDR;
          gnt_d     = gnt_sel;
          wr_d      = req_write[gnt_sel];
          addr_d    = gnt_sel ? req_addr[2*C_ADDR_WIDTH-1:C_ADDR_WIDTH]
                              : req_addr[C_ADDR_WIDTH-1:0];
          wdata_d   = gnt_sel ? req_wdata[2*C_DATA_WIDTH-1:C_DATA_WIDTH]
                              : req_wdata[C_DATA_WIDTH-1:0];
          awvalid_d = req_write[gnt_sel];
          wvalid_d  = req_write[gnt_sel];
          arvalid_d = ~req_write[gnt_sel];
        end
      end
      S_ADDR: begin
        if (wr_q) begin
          // AW and W retire independently; leave once both are gone.
          if (M_AXI_AWREADY) awvalid_d = 1'b0;
          if (M_AXI_WREADY)  wvalid_d  = 1'b0;
          if (!awvalid_d && !wvalid_d) state_d = S_RESP;
        end else if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (wr_q) begin
          bready = 1'b1;
          if (M_AXI_BVALID) begin
            rsp_rdata_d  = '0;
            rsp_resp_d   = M_AXI_BRESP;
            rsp_valid_d  = gnt_q ? 2'b10 : 2'b01;
            last_grant_d = gnt_q;
            state_d      = S_IDLE;
          end
        end else begin
          rready = 1'b1;
          if (M_AXI_RVALID) begin
            rsp_rdata_d  = M_AXI_RDATA;
            rsp_resp_d   = M_AXI_RRESP;
            rsp_valid_d  = gnt_q ? 2'b10 : 2'b01;
            last_grant_d = gnt_q;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_resp_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_resp_q   <= rsp_resp_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready;

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Bench for axil_reg_arbiter: delay-programmable AXI4-Lite slave plus a
// word-memory / round-robin / latency model of the expected behaviour.
module tb_axil_reg_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic ARESETN;
  logic [1:0] req_valid, req_write, req_ready, rsp_valid, rsp_resp;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0] AWPROT, ARPROT;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;
  logic [1:0] BRESP, RRESP;

  axil_reg_arbiter #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID),
    .M_AXI_AWREADY(AWREADY), .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP),
    .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR),
    .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
    .M_AXI_RREADY(RREADY)
  );

  int checks = 0;
  int failures = 0;

  // Slave knobs: cycles of READY/VALID delay per channel and response code.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] slv_resp = 2'b00;
  logic [31:0] slv_mem [4];

  // Reference model state.
  logic [31:0] mdl_mem [4];
  logic mdl_last;

  // Slave BFM: decides at each falling edge what to present for the next rising edge.
  logic aw_arm, aw_hs, w_arm, w_hs, ar_arm, ar_hs, b_arm, r_arm;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic [AW-1:0] s_waddr, s_raddr;
  logic [DW-1:0] s_wdata;

  task automatic slave_clear();
    AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
    BRESP = 0; RRESP = 0; RDATA = 0;
    aw_arm = 0; aw_hs = 0; w_arm = 0; w_hs = 0; ar_arm = 0; ar_hs = 0;
    b_arm = 0; r_arm = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) slv_mem[i] = 32'h0;
    slave_clear();
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        slave_clear();
        continue;
      end
      if (aw_arm) begin aw_arm = 0; aw_hs = 1; AWREADY = 0; end
      else if (AWVALID && !aw_hs) begin
        if (aw_cnt == aw_dly) begin AWREADY = 1; aw_arm = 1; s_waddr = AWADDR; end
        else aw_cnt++;
      end
      if (w_arm) begin w_arm = 0; w_hs = 1; WREADY = 0; end
      else if (WVALID && !w_hs) begin
        if (w_cnt == w_dly) begin WREADY = 1; w_arm = 1; s_wdata = WDATA; end
        else w_cnt++;
      end
      if (ar_arm) begin ar_arm = 0; ar_hs = 1; ARREADY = 0; end
      else if (ARVALID && !ar_hs) begin
        if (ar_cnt == ar_dly) begin ARREADY = 1; ar_arm = 1; s_raddr = ARADDR; end
        else ar_cnt++;
      end
      if (b_arm) begin
        BVALID = 0; b_arm = 0; aw_hs = 0; w_hs = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else if (aw_hs && w_hs && !BVALID) begin
        if (b_cnt == b_dly) begin
          BVALID = 1; BRESP = slv_resp; slv_mem[s_waddr[3:2]] = s_wdata;
        end else b_cnt++;
      end
      if (BVALID && BREADY) b_arm = 1;
      if (r_arm) begin
        RVALID = 0; r_arm = 0; ar_hs = 0; ar_cnt = 0; r_cnt = 0;
      end else if (ar_hs && !RVALID) begin
        if (r_cnt == r_dly) begin
          RVALID = 1; RRESP = slv_resp; RDATA = slv_mem[s_raddr[3:2]];
        end else r_cnt++;
      end
      if (RVALID && RREADY) r_arm = 1;
    end
  end

  task automatic apply_reset();
    @(negedge ACLK);
    req_valid = 0;
    ARESETN = 0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1;
    mdl_last = 1'b1;
  endtask

  // Issue one request from requester n with nobody else requesting and check the completion.
  task automatic do_txn(input int n, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input string tag);
    logic [1:0] exp_oh;
    logic [DW-1:0] exp_rdata;
    logic [1:0] exp_resp;
    int lat, cyc;
    req_write[n] = wr;
    req_addr[n*AW +: AW] = addr;
    req_wdata[n*DW +: DW] = data;
    req_valid[n] = 1'b1;
    #1;
    exp_oh = 2'b01 << n;
    checks++;
    if (req_ready !== exp_oh) begin
      failures++;
      $display("FAIL %s ready: got %b want %b", tag, req_ready, exp_oh);
    end
    lat = wr ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
    exp_rdata = wr ? 32'h0 : mdl_mem[addr[3:2]];
    exp_resp = slv_resp;
    if (wr) mdl_mem[addr[3:2]] = data;
    @(posedge ACLK); #1;
    req_valid[n] = 1'b0;
    req_addr[n*AW +: AW] = ~addr;
    req_wdata[n*DW +: DW] = ~data;
    cyc = 1;
    @(negedge ACLK);
    while (rsp_valid === 2'b00 && cyc < 60) begin @(negedge ACLK); cyc++; end
    checks++;
    if (rsp_valid !== exp_oh || cyc != lat) begin
      failures++;
      $display("FAIL %s rsp_valid: got %b at cycle %0d want %b at cycle %0d", tag, rsp_valid, cyc, exp_oh, lat);
    end
    checks++;
    if (rsp_rdata !== exp_rdata || rsp_resp !== exp_resp) begin
      failures++;
      $display("FAIL %s data: got %h/%0d want %h/%0d", tag, rsp_rdata, rsp_resp, exp_rdata, exp_resp);
    end
    mdl_last = n[0];
    @(negedge ACLK);
    checks++;
    if (rsp_valid !== 2'b00 || rsp_rdata !== exp_rdata || rsp_resp !== exp_resp) begin
      failures++;
      $display("FAIL %s hold: got %b %h %0d want 00 %h %0d", tag, rsp_valid, rsp_rdata, rsp_resp, exp_rdata, exp_resp);
    end
  endtask

  task automatic test_reset();
    ARESETN = 0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_resp, AWVALID, WVALID, ARVALID, BREADY,
         RREADY, AWADDR, WDATA, ARADDR} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got nonzero (ready=%b rsp=%b aw=%b w=%b ar=%b)", req_ready, rsp_valid, AWVALID, WVALID, ARVALID);
    end
    checks++;
    if (AWPROT !== 3'b000 || ARPROT !== 3'b000 || WSTRB !== 4'hF) begin
      failures++;
      $display("FAIL prot_strb: got %b %b %h want 000 000 f", AWPROT, ARPROT, WSTRB);
    end
    apply_reset();
  endtask

  task automatic test_contention();
    int tmo;
    int g;
    logic [1:0] exp_oh;
    logic [DW-1:0] exp_rdata;
    apply_reset();
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; slv_resp = 2'b00;
    req_write = 2'b01;
    req_addr = {4'h4, 4'h4};
    req_wdata = {32'h0, $urandom()};
    req_valid = 2'b11;
    #1;
    for (int unsigned i = 0; i < 4; i++) begin
      tmo = 0;
      while (req_ready === 2'b00 && tmo < 50) begin @(negedge ACLK); #1; tmo++; end
      g = mdl_last ? 0 : 1;
      exp_oh = 2'b01 << g;
      checks++;
      if (req_ready !== exp_oh) begin
        failures++;
        $display("FAIL contention_grant%0d: got %b want %b", i, req_ready, exp_oh);
      end
      if (g == 0) begin exp_rdata = 32'h0; mdl_mem[1] = req_wdata[31:0]; end
      else exp_rdata = mdl_mem[1];
      @(posedge ACLK); #1;
      if (g == 0) req_wdata[31:0] = $urandom();
      tmo = 0;
      @(negedge ACLK);
      while (rsp_valid === 2'b00 && tmo < 50) begin @(negedge ACLK); tmo++; end
      if (i == 3) req_valid = 2'b00;
      checks++;
      if (rsp_valid !== exp_oh || rsp_rdata !== exp_rdata) begin
        failures++;
        $display("FAIL contention_rsp%0d: got %b %h want %b %h", i, rsp_valid, rsp_rdata, exp_oh, exp_rdata);
      end
      mdl_last = g[0];
      #1;
    end
    @(negedge ACLK);
  endtask

  task automatic test_single_write();
    int cyc;
    aw_dly = 0; w_dly = 0; b_dly = 0; slv_resp = 2'b00;
    req_write[0] = 1'b1; req_addr[3:0] = 4'h0; req_wdata[31:0] = 32'h1; req_valid[0] = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL single_ready: got %b want 01", req_ready);
    end
    @(posedge ACLK); #1;
    req_valid[0] = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({AWVALID, WVALID, AWADDR, WDATA, WSTRB} !== {1'b1, 1'b1, 4'h0, 32'h1, 4'hF}) begin
      failures++;
      $display("FAIL single_issue: got aw=%b w=%b addr=%h data=%h strb=%h want 1 1 0 00000001 f", AWVALID, WVALID, AWADDR, WDATA, WSTRB);
    end
    cyc = 1;
    while (rsp_valid === 2'b00 && cyc < 60) begin @(negedge ACLK); cyc++; end
    checks++;
    if (rsp_valid !== 2'b01 || cyc != 3 || rsp_resp !== 2'b00) begin
      failures++;
      $display("FAIL single_rsp: got %b cycle %0d resp %0d want 01 cycle 3 resp 0", rsp_valid, cyc, rsp_resp);
    end
    mdl_mem[0] = 32'h1;
    mdl_last = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic test_write_readback();
    for (int unsigned i = 0; i < 4; i++) do_txn(0, 1'b1, 4'(i * 4), 32'(i + 1), "wrb_write");
    for (int unsigned i = 0; i < 4; i++) begin
      do_txn(1, 1'b0, 4'(i * 4), 32'h0, "wrb_read");
      checks++;
      if (rsp_rdata !== 32'(i + 1)) begin
        failures++;
        $display("FAIL wrb_value%0d: got %h want %h", i, rsp_rdata, i + 1);
      end
    end
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 20; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      r_dly = $urandom_range(0, 3); slv_resp = 2'($urandom_range(0, 3));
      do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 3) * 4), $urandom(), "random");
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; slv_resp = 2'b00;
  endtask

  // Model of a skewed write: each valid drops after its own ready, RESP only once both have.
  task automatic test_skew(input int d_aw, input int d_w, input string tag);
    int aw_last, w_last, resp_cyc, rsp_cyc, pulses;
    logic [3:0] exp_v, got_v;
    logic [DW-1:0] data;
    aw_dly = d_aw; w_dly = d_w; b_dly = 0;
    data = $urandom();
    aw_last = 1 + d_aw; w_last = 1 + d_w;
    resp_cyc = ((aw_last > w_last) ? aw_last : w_last) + 1;
    rsp_cyc = resp_cyc + 1;
    pulses = 0;
    req_write[0] = 1'b1; req_addr[3:0] = 4'h8; req_wdata[31:0] = data; req_valid[0] = 1'b1;
    @(posedge ACLK); #1;
    req_valid[0] = 1'b0;
    mdl_mem[2] = data;
    for (int c = 1; c <= rsp_cyc + 2; c++) begin
      @(negedge ACLK);
      got_v = {AWVALID, WVALID, BREADY, rsp_valid != 2'b00};
      exp_v = {c <= aw_last, c <= w_last, c == resp_cyc, c == rsp_cyc};
      if (rsp_valid != 2'b00) pulses++;
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL %s cycle%0d aw/w/bready/rsp: got %b want %b", tag, c, got_v, exp_v);
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL %s pulses: got %0d want 1", tag, pulses);
    end
    mdl_last = 1'b0;
    aw_dly = 0; w_dly = 0;
  endtask

  task automatic test_stall_reset();
    int seen, cyc;
    r_dly = 10;
    req_write[1] = 1'b0; req_addr[7:4] = 4'h8; req_valid[1] = 1'b1;
    @(posedge ACLK); #1;
    req_valid[1] = 1'b0;
    repeat (5) @(negedge ACLK);
    checks++;
    if (RREADY !== 1'b1) begin
      failures++;
      $display("FAIL stall_rready: got %b want 1", RREADY);
    end
    ARESETN = 0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_resp, AWVALID, WVALID, ARVALID, BREADY,
         RREADY, AWADDR, WDATA, ARADDR} !== '0) begin
      failures++;
      $display("FAIL stall_reset_outputs: got nonzero (rsp=%b rdata=%h rready=%b araddr=%h)", rsp_valid, rsp_rdata, RREADY, ARADDR);
    end
    seen = 0;
    repeat (2) begin @(negedge ACLK); if (rsp_valid !== 2'b00) seen++; end
    ARESETN = 1;
    mdl_last = 1'b1;
    r_dly = 0;
    repeat (15) begin @(negedge ACLK); if (rsp_valid !== 2'b00) seen++; end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL stall_no_rsp: got %0d pulses want 0", seen);
    end
    req_write = 2'b01; req_addr = {4'h8, 4'hC}; req_wdata = {32'h0, 32'hC0FFEE00};
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL stall_first_grant: got %b want 01", req_ready);
    end
    @(posedge ACLK); #1;
    req_valid = 2'b00;
    mdl_mem[3] = 32'hC0FFEE00;
    cyc = 1;
    @(negedge ACLK);
    while (rsp_valid === 2'b00 && cyc < 60) begin @(negedge ACLK); cyc++; end
    checks++;
    if (rsp_valid !== 2'b01 || cyc != 3) begin
      failures++;
      $display("FAIL stall_after_rsp: got %b cycle %0d want 01 cycle 3", rsp_valid, cyc);
    end
    mdl_last = 1'b0;
    @(negedge ACLK);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mdl_mem[i] = 32'h0;
    mdl_last = 1'b1;
    test_reset();
    test_single_write();
    test_write_readback();
    test_contention();
    test_random();
    test_skew(3, 0, "skew_w_first");
    test_skew(0, 3, "skew_aw_first");
    test_stall_reset();
    do_txn(1, 1'b0, 4'hC, 32'h0, "final_read");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
